// File: rtl/riscv_wb_pkg.sv
// Shared register-file writeback types and helpers for the load writeback path.
package riscv_wb_pkg;
  localparam int WB_ADDR_W = 6;
  localparam int WB_DATA_W = 32;
  localparam logic [WB_ADDR_W-1:0] REG_ZERO_ADDR = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
    logic                 we;
  } wb_req_t;

  // Only x0 is hardwired; f0 (addr 32) is a real register.
  function automatic logic is_zero_reg(input logic [WB_ADDR_W-1:0] addr);
    return addr == REG_ZERO_ADDR;
  endfunction
endpackage

// File: rtl/riscv_wb_addr_fifo.sv
// Circular address FIFO for outstanding loads; exports every entry and its valid bit
// so the top level can compare decode read addresses against pending destinations.
module riscv_wb_addr_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic [ADDR_WIDTH-1:0]              push_addr,
  input  logic                               pop,
  output logic [ADDR_WIDTH-1:0]              head_addr,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0]   entry_addr,
  output logic [DEPTH-1:0]                   entry_valid,
  output logic [$clog2(DEPTH)-1:0]           rptr,
  output logic [$clog2(DEPTH):0]             count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_addr;
  end

  // Callers gate push with not-full and pop with not-empty, so count stays in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        wptr              <= wptr + PTR_W'(1);
        entry_valid[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr              <= rptr + PTR_W'(1);
        entry_valid[rptr] <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_addr  = mem[rptr];
  assign entry_addr = mem;
endmodule

// File: rtl/riscv_load_wb_queue.sv
// In-order load writeback queue driving register-file port B, with decode hazard detection.
// Optional macro RISCV_LOAD_WB_BYPASS_EN: zero-latency combinational write port.
module riscv_load_wb_queue
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int FPU        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ADDR_WIDTH-1:0]    issue_waddr_i,
  input  logic                     resp_valid_i,
  input  logic [DATA_WIDTH-1:0]    resp_rdata_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]    raddr_c_i,
  output logic                     hazard_o,
  output logic [ADDR_WIDTH-1:0]    waddr_b_o,
  output logic [DATA_WIDTH-1:0]    wdata_b_o,
  output logic                     we_b_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if ((FPU != 0 && ADDR_WIDTH != 6) || (FPU == 0 && ADDR_WIDTH != 5)) begin : g_bad_addr_w
    $error("ADDR_WIDTH must be 6 with the fp bank, 5 without");
  end

  logic                             accept;
  logic                             pop;
  logic [ADDR_WIDTH-1:0]            head_addr;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0]                 live_valid;
  logic [PTR_W-1:0]                 rptr;
  logic [2:0][ADDR_WIDTH-1:0]       raddr;
  wb_req_t                          wb_p0;

  // Ready looks only at the registered count so it never depends on resp_valid_i.
  assign issue_ready_o = outstanding_o < CNT_W'(DEPTH);
  assign accept        = issue_valid_i && issue_ready_o;
  assign pop           = resp_valid_i && (outstanding_o != '0);

  riscv_wb_addr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .push_addr   (issue_waddr_i),
    .pop         (pop),
    .head_addr   (head_addr),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid),
    .rptr        (rptr),
    .count       (outstanding_o)
  );

  always_comb begin
    wb_p0.waddr = WB_ADDR_W'(head_addr);
    wb_p0.wdata = WB_DATA_W'(resp_rdata_i);
    wb_p0.we    = pop && !is_zero_reg(wb_p0.waddr);
  end

  always_ff @(posedge clk) begin
    if (rst) err_o <= 1'b0;
    else     err_o <= resp_valid_i && (outstanding_o == '0);
  end

`ifdef RISCV_LOAD_WB_BYPASS_EN
  assign waddr_b_o  = wb_p0.waddr[ADDR_WIDTH-1:0];
  assign wdata_b_o  = wb_p0.wdata[DATA_WIDTH-1:0];
  assign we_b_o     = wb_p0.we;
  // The head being written this cycle is already visible to the reader.
  assign live_valid = entry_valid & ~(pop ? (DEPTH'(1) << rptr) : DEPTH'(0));
`else
  wb_req_t wb_p1;

  // Stage p0 -> p1: register-file write port register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_p1 <= '0;
    end else begin
      wb_p1.we <= wb_p0.we;
      if (pop) begin
        wb_p1.waddr <= wb_p0.waddr;
        wb_p1.wdata <= wb_p0.wdata;
      end
    end
  end

  assign waddr_b_o  = wb_p1.waddr[ADDR_WIDTH-1:0];
  assign wdata_b_o  = wb_p1.wdata[DATA_WIDTH-1:0];
  assign we_b_o     = wb_p1.we;
  assign live_valid = entry_valid;
`endif

  assign raddr = {raddr_c_i, raddr_b_i, raddr_a_i};

  always_comb begin
    hazard_o = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!is_zero_reg(WB_ADDR_W'(raddr[k]))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (live_valid[i] && entry_addr[i] == raddr[k]) hazard_o = 1'b1;
        end
`ifndef RISCV_LOAD_WB_BYPASS_EN
        // Register file only updates at the next edge, so the pending write still hazards.
        if (wb_p1.we && wb_p1.waddr == WB_ADDR_W'(raddr[k])) hazard_o = 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_riscv_load_wb_queue.sv
// Directed bench for riscv_load_wb_queue (DEPTH=2, FPU=0).
module tb_riscv_load_wb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [4:0]  issue_waddr_i;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic [4:0]  raddr_a_i, raddr_b_i, raddr_c_i;
  logic        hazard_o;
  logic [4:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        we_b_o;
  logic [1:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  riscv_load_wb_queue #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32),
    .DEPTH      (2),
    .FPU        (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_waddr_i (issue_waddr_i),
    .resp_valid_i  (resp_valid_i),
    .resp_rdata_i  (resp_rdata_i),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .raddr_c_i     (raddr_c_i),
    .hazard_o      (hazard_o),
    .waddr_b_o     (waddr_b_o),
    .wdata_b_o     (wdata_b_o),
    .we_b_o        (we_b_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_waddr_i = '0;
    resp_valid_i  = 1'b0; resp_rdata_i  = '0;
    raddr_a_i = '0; raddr_b_i = '0; raddr_c_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    raddr_a_i = 5'd5; #1;
    total++; if (outstanding_o !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", outstanding_o); end
    total++; if (we_b_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b want=0", we_b_o); end
    total++; if (waddr_b_o !== 5'd0) begin bad++; $display("FAIL rst_waddr got=%0d want=0", waddr_b_o); end
    total++; if (wdata_b_o !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%0h want=0", wdata_b_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b want=0", err_o); end
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL rst_hazard got=%0b want=0", hazard_o); end
    total++; if (issue_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", issue_ready_o); end
    raddr_a_i = '0;
  endtask

  task automatic test_err();
    resp_valid_i = 1'b1; resp_rdata_i = 32'h1234;
    tick();
    resp_valid_i = 1'b0;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b want=1", err_o); end
    total++; if (we_b_o !== 1'b0) begin bad++; $display("FAIL err_we got=%0b want=0", we_b_o); end
    total++; if (outstanding_o !== 2'd0) begin bad++; $display("FAIL err_count got=%0d want=0", outstanding_o); end
    tick();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", err_o); end
  endtask

`ifndef RISCV_LOAD_WB_BYPASS_EN
  task automatic test_single();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd5;
    tick();
    issue_valid_i = 1'b0;
    total++; if (outstanding_o !== 2'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", outstanding_o); end
    tick(); tick();
    total++; if (we_b_o !== 1'b0) begin bad++; $display("FAIL single_we_idle got=%0b want=0", we_b_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'hDEADBEEF;
    tick();
    resp_valid_i = 1'b0;
    total++; if (we_b_o !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", we_b_o); end
    total++; if (waddr_b_o !== 5'd5) begin bad++; $display("FAIL single_waddr got=%0d want=5", waddr_b_o); end
    total++; if (wdata_b_o !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%0h want=deadbeef", wdata_b_o); end
    total++; if (outstanding_o !== 2'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", outstanding_o); end
    tick();
    total++; if (we_b_o !== 1'b0) begin bad++; $display("FAIL single_we_drop got=%0b want=0", we_b_o); end
  endtask

  task automatic test_back_to_back();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd7; tick();
    issue_waddr_i = 5'd9; tick();
    total++; if (issue_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%0b want=0", issue_ready_o); end
    total++; if (outstanding_o !== 2'd2) begin bad++; $display("FAIL b2b_count2 got=%0d want=2", outstanding_o); end
    issue_waddr_i = 5'd11; tick();
    issue_valid_i = 1'b0;
    total++; if (outstanding_o !== 2'd2) begin bad++; $display("FAIL b2b_ignored got=%0d want=2", outstanding_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'h1; tick();
    total++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd7 || wdata_b_o !== 32'h1) begin bad++; $display("FAIL b2b_wr1 got=%0b/%0d/%0h want=1/7/1", we_b_o, waddr_b_o, wdata_b_o); end
    resp_rdata_i = 32'h2; tick();
    resp_valid_i = 1'b0;
    total++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd9 || wdata_b_o !== 32'h2) begin bad++; $display("FAIL b2b_wr2 got=%0b/%0d/%0h want=1/9/2", we_b_o, waddr_b_o, wdata_b_o); end
    total++; if (outstanding_o !== 2'd0) begin bad++; $display("FAIL b2b_count0 got=%0d want=0", outstanding_o); end
    tick();
    total++; if (we_b_o !== 1'b0) begin bad++; $display("FAIL b2b_we_drop got=%0b want=0", we_b_o); end
  endtask

  task automatic test_hazard();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd3; tick();
    issue_valid_i = 1'b0;
    raddr_a_i = 5'd4; #1;
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL haz_nomatch got=%0b want=0", hazard_o); end
    raddr_b_i = 5'd3; #1;
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL haz_pending got=%0b want=1", hazard_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'h33; tick();
    resp_valid_i = 1'b0;
    total++; if (we_b_o !== 1'b1 || hazard_o !== 1'b1) begin bad++; $display("FAIL haz_during_we got=%0b/%0b want=1/1", we_b_o, hazard_o); end
    tick();
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL haz_cleared got=%0b want=0", hazard_o); end
    raddr_a_i = 5'd0; raddr_b_i = 5'd0;
    issue_valid_i = 1'b1; issue_waddr_i = 5'd0; tick();
    issue_valid_i = 1'b0;
    total++; if (hazard_o !== 1'b0 || outstanding_o !== 2'd1) begin bad++; $display("FAIL haz_x0 got=%0b/%0d want=0/1", hazard_o, outstanding_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'h77; tick();
    resp_valid_i = 1'b0;
    total++; if (we_b_o !== 1'b0 || outstanding_o !== 2'd0) begin bad++; $display("FAIL x0_nowrite got=%0b/%0d want=0/0", we_b_o, outstanding_o); end
    tick();
  endtask

  task automatic test_simultaneous();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd8; tick();
    issue_waddr_i = 5'd4; resp_valid_i = 1'b1; resp_rdata_i = 32'h55; tick();
    issue_valid_i = 1'b0; resp_valid_i = 1'b0;
    total++; if (outstanding_o !== 2'd1) begin bad++; $display("FAIL sim_count got=%0d want=1", outstanding_o); end
    total++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd8 || wdata_b_o !== 32'h55) begin bad++; $display("FAIL sim_wr got=%0b/%0d/%0h want=1/8/55", we_b_o, waddr_b_o, wdata_b_o); end
    raddr_c_i = 5'd4; tick();
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL sim_head_haz got=%0b want=1", hazard_o); end
    raddr_c_i = 5'd0;
    resp_valid_i = 1'b1; resp_rdata_i = 32'h66; tick();
    resp_valid_i = 1'b0;
    total++; if (waddr_b_o !== 5'd4 || wdata_b_o !== 32'h66) begin bad++; $display("FAIL sim_head got=%0d/%0h want=4/66", waddr_b_o, wdata_b_o); end
    // Full queue: issue alongside a pop must be refused.
    issue_valid_i = 1'b1; issue_waddr_i = 5'd1; tick();
    issue_waddr_i = 5'd2; tick();
    issue_waddr_i = 5'd13; resp_valid_i = 1'b1; resp_rdata_i = 32'hA1; tick();
    issue_valid_i = 1'b0;
    total++; if (outstanding_o !== 2'd1 || waddr_b_o !== 5'd1) begin bad++; $display("FAIL full_pop got=%0d/%0d want=1/1", outstanding_o, waddr_b_o); end
    resp_rdata_i = 32'hA2; tick();
    total++; if (waddr_b_o !== 5'd2 || outstanding_o !== 2'd0) begin bad++; $display("FAIL full_pop2 got=%0d/%0d want=2/0", waddr_b_o, outstanding_o); end
    tick();
    resp_valid_i = 1'b0;
    total++; if (err_o !== 1'b1 || we_b_o !== 1'b0) begin bad++; $display("FAIL full_refused got=%0b/%0b want=1/0", err_o, we_b_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd10; tick();
    issue_waddr_i = 5'd12; tick();
    issue_valid_i = 1'b0;
    total++; if (outstanding_o !== 2'd2) begin bad++; $display("FAIL mid_count2 got=%0d want=2", outstanding_o); end
    do_reset();
    tick(); tick();
    total++; if (outstanding_o !== 2'd0 || we_b_o !== 1'b0) begin bad++; $display("FAIL mid_cleared got=%0d/%0b want=0/0", outstanding_o, we_b_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'hBB; tick();
    resp_valid_i = 1'b0;
    total++; if (err_o !== 1'b1 || we_b_o !== 1'b0) begin bad++; $display("FAIL mid_nowrite got=%0b/%0b want=1/0", err_o, we_b_o); end
    tick();
  endtask
`else
  task automatic test_bypass();
    issue_valid_i = 1'b1; issue_waddr_i = 5'd6; tick();
    issue_valid_i = 1'b0;
    raddr_c_i = 5'd6; #1;
    total++; if (hazard_o !== 1'b1) begin bad++; $display("FAIL byp_haz got=%0b want=1", hazard_o); end
    resp_valid_i = 1'b1; resp_rdata_i = 32'hA5; #1;
    total++; if (we_b_o !== 1'b1 || waddr_b_o !== 5'd6 || wdata_b_o !== 32'hA5) begin bad++; $display("FAIL byp_wr got=%0b/%0d/%0h want=1/6/a5", we_b_o, waddr_b_o, wdata_b_o); end
    total++; if (hazard_o !== 1'b0) begin bad++; $display("FAIL byp_haz_drop got=%0b want=0", hazard_o); end
    tick();
    resp_valid_i = 1'b0; #1;
    total++; if (we_b_o !== 1'b0 || outstanding_o !== 2'd0) begin bad++; $display("FAIL byp_after got=%0b/%0d want=0/0", we_b_o, outstanding_o); end
    raddr_c_i = '0;
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_err();
`ifndef RISCV_LOAD_WB_BYPASS_EN
    test_single();
    test_back_to_back();
    test_hazard();
    test_simultaneous();
    test_reset_mid();
`else
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
